// File: rtl/interrupt_sequencer.sv
// Interrupt entry/return sequencer: drains the pipeline, pushes the resume PC, fetches the
// handler vector over the shared data-memory port, and unwinds the stack on RTI.
module interrupt_sequencer #(
  parameter logic [15:0] VEC_ADDR     = 16'h0000,
  parameter int unsigned DRAIN_CYCLES = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        interrupt_i,
  input  logic        branch_pending_i,
  input  logic [31:0] resume_pc_i,
  input  logic [3:0]  ccr_i,
  input  logic        rti_i,
  input  logic        mem_gnt_i,
  input  logic [15:0] mem_rdata_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_use_sp_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  output logic [1:0]  sp_op_o,
  output logic        stall_o,
  output logic        pc_load_o,
  output logic [31:0] pc_value_o,
  output logic        flags_restore_o,
  output logic [3:0]  flags_out_o,
  output logic        int_active_o
);

  typedef enum logic [3:0] {
    IDLE, DRAIN, PUSH_HI, PUSH_LO, VEC_HI, VEC_LO, JUMP, SERVICE, POP_LO, POP_HI, RETURN
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic        int_prev_q, pend_q, pend_d, int_edge;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] saved_pc_q, saved_pc_d, vec_q, vec_d, ret_q, ret_d;
  logic [3:0]  saved_ccr_q, saved_ccr_d;

  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d, mem_use_sp_q, mem_use_sp_d;
  logic [15:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [1:0]  sp_op_q, sp_op_d;
  logic        stall_q, stall_d, pc_load_q, pc_load_d;
  logic [31:0] pc_value_q, pc_value_d;
  logic        flags_restore_q, flags_restore_d, int_active_q, int_active_d;
  logic [3:0]  flags_out_q, flags_out_d;

  assign int_edge = interrupt_i & ~int_prev_q;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q | int_edge;
    cnt_d       = cnt_q;
    saved_pc_d  = saved_pc_q;
    saved_ccr_d = saved_ccr_q;
    vec_d       = vec_q;
    ret_d       = ret_q;

    case (state_q)
      IDLE: if ((pend_q | int_edge) && !branch_pending_i) begin
        saved_pc_d  = resume_pc_i;
        saved_ccr_d = ccr_i;
        pend_d      = 1'b0;
        cnt_d       = CNT_INIT;
        state_d     = DRAIN;
      end
      DRAIN: begin
        if (cnt_q == 3'd0) state_d = PUSH_HI;
        else               cnt_d   = cnt_q - 3'd1;
      end
      PUSH_HI: if (mem_gnt_i) state_d = PUSH_LO;
      PUSH_LO: if (mem_gnt_i) state_d = VEC_HI;
      VEC_HI: if (mem_gnt_i) begin
        vec_d[31:16] = mem_rdata_i;
        state_d      = VEC_LO;
      end
      VEC_LO: if (mem_gnt_i) begin
        vec_d[15:0] = mem_rdata_i;
        state_d     = JUMP;
      end
      JUMP:    state_d = SERVICE;
      SERVICE: if (rti_i) state_d = POP_LO;
      POP_LO: if (mem_gnt_i) begin
        ret_d[15:0] = mem_rdata_i;
        state_d     = POP_HI;
      end
      POP_HI: if (mem_gnt_i) begin
        ret_d[31:16] = mem_rdata_i;
        state_d      = RETURN;
      end
      RETURN:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they register alongside it.
    mem_req_d       = 1'b0;
    mem_we_d        = 1'b0;
    mem_use_sp_d    = 1'b0;
    mem_addr_d      = 16'h0000;
    mem_wdata_d     = 16'h0000;
    sp_op_d         = 2'b00;
    stall_d         = 1'b0;
    pc_load_d       = 1'b0;
    pc_value_d      = 32'h0;
    flags_restore_d = 1'b0;
    flags_out_d     = 4'h0;
    int_active_d    = 1'b0;

    case (state_d)
      DRAIN: stall_d = 1'b1;
      PUSH_HI, PUSH_LO: begin
        mem_req_d    = 1'b1;
        mem_we_d     = 1'b1;
        mem_use_sp_d = 1'b1;
        sp_op_d      = 2'b01;
        stall_d      = 1'b1;
        mem_wdata_d  = (state_d == PUSH_HI) ? saved_pc_d[31:16] : saved_pc_d[15:0];
      end
      VEC_HI, VEC_LO: begin
        mem_req_d  = 1'b1;
        stall_d    = 1'b1;
        mem_addr_d = (state_d == VEC_HI) ? VEC_ADDR : VEC_ADDR + 16'd1;
      end
      JUMP: begin
        stall_d      = 1'b1;
        pc_load_d    = 1'b1;
        pc_value_d   = vec_d;
        int_active_d = 1'b1;
      end
      SERVICE: int_active_d = 1'b1;
      POP_LO, POP_HI: begin
        mem_req_d    = 1'b1;
        mem_use_sp_d = 1'b1;
        sp_op_d      = 2'b10;
        stall_d      = 1'b1;
        int_active_d = 1'b1;
      end
      RETURN: begin
        stall_d         = 1'b1;
        pc_load_d       = 1'b1;
        pc_value_d      = ret_d;
        flags_restore_d = 1'b1;
        flags_out_d     = saved_ccr_d;
        int_active_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= IDLE;
      int_prev_q      <= 1'b1;  // a level still high at reset release is not a fresh edge
      pend_q          <= 1'b0;
      cnt_q           <= 3'd0;
      saved_pc_q      <= 32'h0;
      saved_ccr_q     <= 4'h0;
      vec_q           <= 32'h0;
      ret_q           <= 32'h0;
      mem_req_q       <= 1'b0;
      mem_we_q        <= 1'b0;
      mem_use_sp_q    <= 1'b0;
      mem_addr_q      <= 16'h0000;
      mem_wdata_q     <= 16'h0000;
      sp_op_q         <= 2'b00;
      stall_q         <= 1'b0;
      pc_load_q       <= 1'b0;
      pc_value_q      <= 32'h0;
      flags_restore_q <= 1'b0;
      flags_out_q     <= 4'h0;
      int_active_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      int_prev_q      <= interrupt_i;
      pend_q          <= pend_d;
      cnt_q           <= cnt_d;
      saved_pc_q      <= saved_pc_d;
      saved_ccr_q     <= saved_ccr_d;
      vec_q           <= vec_d;
      ret_q           <= ret_d;
      mem_req_q       <= mem_req_d;
      mem_we_q        <= mem_we_d;
      mem_use_sp_q    <= mem_use_sp_d;
      mem_addr_q      <= mem_addr_d;
      mem_wdata_q     <= mem_wdata_d;
      sp_op_q         <= sp_op_d;
      stall_q         <= stall_d;
      pc_load_q       <= pc_load_d;
      pc_value_q      <= pc_value_d;
      flags_restore_q <= flags_restore_d;
      flags_out_q     <= flags_out_d;
      int_active_q    <= int_active_d;
    end
  end

  assign mem_req_o       = mem_req_q;
  assign mem_we_o        = mem_we_q;
  assign mem_use_sp_o    = mem_use_sp_q;
  assign mem_addr_o      = mem_addr_q;
  assign mem_wdata_o     = mem_wdata_q;
  assign sp_op_o         = sp_op_q;
  assign stall_o         = stall_q;
  assign pc_load_o       = pc_load_q;
  assign pc_value_o      = pc_value_q;
  assign flags_restore_o = flags_restore_q;
  assign flags_out_o     = flags_out_q;
  assign int_active_o    = int_active_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: directed scenario tasks plus a step-script reference model
// with a stack/vector memory that answers the sequencer's data-memory requests.
module tb_interrupt_sequencer;

  localparam logic [15:0] VA = 16'hFFFF;
  localparam int DC = 3;

  logic        clk = 1'b0;
  logic        rst_n, intr, bp, rti, gnt;
  logic [31:0] rpc;
  logic [3:0]  ccr;
  logic [15:0] rdata;
  logic        mem_req, mem_we, mem_use_sp, stall, pc_load, flags_restore, int_active;
  logic [15:0] mem_addr, mem_wdata;
  logic [1:0]  sp_op;
  logic [31:0] pc_value;
  logic [3:0]  flags_out;
  logic [76:0] dut_vec;

  int checks = 0;
  int failures = 0;
  bit sb_en = 1'b0;

  always #5 clk = ~clk;

  interrupt_sequencer #(.VEC_ADDR(VA), .DRAIN_CYCLES(DC)) dut (
    .clk_i(clk), .rst_ni(rst_n), .interrupt_i(intr), .branch_pending_i(bp),
    .resume_pc_i(rpc), .ccr_i(ccr), .rti_i(rti), .mem_gnt_i(gnt), .mem_rdata_i(rdata),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_use_sp_o(mem_use_sp),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .sp_op_o(sp_op), .stall_o(stall),
    .pc_load_o(pc_load), .pc_value_o(pc_value), .flags_restore_o(flags_restore),
    .flags_out_o(flags_out), .int_active_o(int_active)
  );

  assign dut_vec = {mem_req, mem_we, mem_use_sp, mem_addr, mem_wdata, sp_op, stall,
                    pc_load, pc_value, flags_restore, flags_out, int_active};

  // Reference model: a script of pending steps, consumed as grants and rti arrive.
  typedef enum int {K_DRAIN, K_PUSH_HI, K_PUSH_LO, K_VEC_HI, K_VEC_LO, K_JUMP,
                    K_SERVICE, K_POP_LO, K_POP_HI, K_RETURN} kind_e;
  kind_e       script[$];
  logic        m_prev, m_pend;
  logic [31:0] m_pc, m_vec, m_ret;
  logic [3:0]  m_ccr;
  logic [7:0]  m_sp = 8'h80;
  logic [15:0] stk [0:255];
  logic [15:0] vec_hi_w = 16'h0000;
  logic [15:0] vec_lo_w = 16'h0100;

  function automatic logic [76:0] expected_outputs();
    logic req = 0, we = 0, usp = 0, stl = 0, pcl = 0, fr = 0, ia = 0;
    logic [15:0] addr = 0, wd = 0;
    logic [1:0]  spo = 0;
    logic [31:0] pcv = 0;
    logic [3:0]  fo = 0;
    if (script.size() != 0) begin
      case (script[0])
        K_DRAIN:   stl = 1;
        K_PUSH_HI: begin req = 1; we = 1; usp = 1; spo = 2'b01; stl = 1; wd = m_pc[31:16]; end
        K_PUSH_LO: begin req = 1; we = 1; usp = 1; spo = 2'b01; stl = 1; wd = m_pc[15:0]; end
        K_VEC_HI:  begin req = 1; stl = 1; addr = VA; end
        K_VEC_LO:  begin req = 1; stl = 1; addr = 16'(VA + 16'd1); end
        K_JUMP:    begin stl = 1; pcl = 1; pcv = m_vec; ia = 1; end
        K_SERVICE: ia = 1;
        K_POP_LO, K_POP_HI: begin req = 1; usp = 1; spo = 2'b10; stl = 1; ia = 1; end
        K_RETURN:  begin stl = 1; pcl = 1; pcv = m_ret; fr = 1; fo = m_ccr; ia = 1; end
        default: ;
      endcase
    end
    return {req, we, usp, addr, wd, spo, stl, pcl, pcv, fr, fo, ia};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev = 1'b1;
      m_pend = 1'b0;
      script.delete();
      m_pc = '0; m_ccr = '0; m_vec = '0; m_ret = '0;
      rdata <= 16'h0;
    end else begin
      logic edge_s;
      edge_s = intr & ~m_prev;
      m_prev = intr;
      if (script.size() == 0) begin
        if ((m_pend | edge_s) && !bp) begin
          m_pc = rpc; m_ccr = ccr; m_pend = 1'b0;
          repeat (DC) script.push_back(K_DRAIN);
          script.push_back(K_PUSH_HI); script.push_back(K_PUSH_LO);
          script.push_back(K_VEC_HI);  script.push_back(K_VEC_LO);
          script.push_back(K_JUMP);    script.push_back(K_SERVICE);
        end else m_pend = m_pend | edge_s;
      end else begin
        m_pend = m_pend | edge_s;
        case (script[0])
          K_DRAIN, K_JUMP, K_RETURN: void'(script.pop_front());
          K_PUSH_HI: if (gnt) begin stk[m_sp] = m_pc[31:16]; m_sp = m_sp - 8'd1; void'(script.pop_front()); end
          K_PUSH_LO: if (gnt) begin stk[m_sp] = m_pc[15:0];  m_sp = m_sp - 8'd1; void'(script.pop_front()); end
          K_VEC_HI:  if (gnt) begin m_vec[31:16] = rdata; void'(script.pop_front()); end
          K_VEC_LO:  if (gnt) begin m_vec[15:0]  = rdata; void'(script.pop_front()); end
          K_SERVICE: if (rti) begin
            void'(script.pop_front());
            script.push_back(K_POP_LO); script.push_back(K_POP_HI); script.push_back(K_RETURN);
          end
          K_POP_LO:  if (gnt) begin m_sp = m_sp + 8'd1; m_ret[15:0]  = rdata; void'(script.pop_front()); end
          K_POP_HI:  if (gnt) begin m_sp = m_sp + 8'd1; m_ret[31:16] = rdata; void'(script.pop_front()); end
          default: ;
        endcase
      end
      if (script.size() != 0 && script[0] == K_VEC_HI)      rdata <= vec_hi_w;
      else if (script.size() != 0 && script[0] == K_VEC_LO) rdata <= vec_lo_w;
      else if (script.size() != 0 && (script[0] == K_POP_LO || script[0] == K_POP_HI))
        rdata <= stk[8'(m_sp + 8'd1)];
      else rdata <= 16'($urandom);
    end
  end

  always @(negedge clk) begin
    if (sb_en) begin
      logic [76:0] want;
      want = expected_outputs();
      checks++;
      if (dut_vec !== want) begin
        failures++;
        $display("FAIL scoreboard t=%0t got=%h want=%h", $time, dut_vec, want);
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_return();
    rti = 1'b1; tick(); rti = 1'b0; tick(3);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; intr = 0; bp = 0; rti = 0; gnt = 1; rpc = '0; ccr = '0;
    tick(2);
    sb_en = 1'b1;
    checks++;
    if (dut_vec !== 77'h0) begin failures++; $display("FAIL reset_outputs got=%h want=0", dut_vec); end
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_basic_entry();
    rpc = 32'h0001_0020; ccr = 4'b0101; gnt = 1; vec_hi_w = 16'h0000; vec_lo_w = 16'h0100;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL entry_c0_stall got=%b want=0", stall); end
    intr = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      if (c == 2) intr = 1'b0;
      if (c == 1) rpc = $urandom;
      checks++;
      if (stall !== 1'b1) begin failures++; $display("FAIL entry_stall c=%0d got=%b want=1", c, stall); end
      if (c == 4 || c == 5) begin
        checks++;
        if ({mem_req, mem_we, mem_use_sp, sp_op, mem_wdata} !== {3'b111, 2'b01, (c == 4) ? 16'h0001 : 16'h0020}) begin
          failures++;
          $display("FAIL entry_push c=%0d got wdata=%h sp_op=%b want wdata=%h sp_op=01", c, mem_wdata, sp_op, (c == 4) ? 16'h0001 : 16'h0020);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (mem_addr !== ((c == 6) ? 16'hFFFF : 16'h0000)) begin
          failures++; $display("FAIL entry_vec_addr c=%0d got=%h want=%h", c, mem_addr, (c == 6) ? 16'hFFFF : 16'h0000);
        end
      end
      if (c == 8) begin
        checks++;
        if ({pc_load, pc_value} !== {1'b1, 32'h0000_0100}) begin
          failures++; $display("FAIL entry_jump got pc_load=%b pc_value=%h want 1/00000100", pc_load, pc_value);
        end
      end
    end
    tick();
    checks++;
    if ({int_active, stall} !== 2'b10) begin failures++; $display("FAIL entry_service got ia=%b stall=%b want 1/0", int_active, stall); end
  endtask

  task automatic test_return();
    rti = 1'b1;
    tick(); rti = 1'b0;
    checks++;
    if ({mem_req, mem_we, mem_use_sp, sp_op} !== 5'b10110) begin
      failures++; $display("FAIL return_pop got req=%b we=%b usp=%b sp_op=%b want 1/0/1/10", mem_req, mem_we, mem_use_sp, sp_op);
    end
    tick(2);
    checks++;
    if ({pc_load, pc_value, flags_restore, flags_out} !== {1'b1, 32'h0001_0020, 1'b1, 4'b0101}) begin
      failures++; $display("FAIL return_restore got pc=%h fr=%b fo=%b want 00010020/1/0101", pc_value, flags_restore, flags_out);
    end
    tick();
    checks++;
    if ({stall, int_active, pc_load} !== 3'b000) begin failures++; $display("FAIL return_idle got %b want 000", {stall, int_active, pc_load}); end
  endtask

  task automatic test_grant_starvation();
    rpc = 32'h0001_0020; gnt = 1; intr = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick();
      intr = 1'b0;
      gnt = (c >= 5 && c <= 8) ? 1'b0 : 1'b1;
      if (c >= 5 && c <= 9) begin
        checks++;
        if ({mem_req, mem_we, sp_op, mem_wdata} !== {2'b11, 2'b01, 16'h0020}) begin
          failures++; $display("FAIL starve_hold c=%0d got wdata=%h sp_op=%b want 0020/01", c, mem_wdata, sp_op);
        end
      end
      if (c == 8 || c == 12) begin
        checks++;
        if (pc_load !== (c == 12)) begin failures++; $display("FAIL starve_jump c=%0d got=%b want=%b", c, pc_load, c == 12); end
      end
    end
    tick();
    do_return();
    tick();
  endtask

  task automatic test_branch_collision();
    logic [31:0] pc_c;
    pc_c = $urandom;
    intr = 1'b1; bp = 1'b1; rpc = $urandom;
    tick(); rpc = $urandom;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL branch_c1_stall got=%b want=0", stall); end
    tick(); bp = 1'b0; rpc = pc_c; intr = 1'b0;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL branch_c2_stall got=%b want=0", stall); end
    tick(); rpc = $urandom;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL branch_c3_drain got=%b want=1", stall); end
    tick(3);
    checks++;
    if (mem_wdata !== pc_c[31:16]) begin failures++; $display("FAIL branch_push_hi got=%h want=%h", mem_wdata, pc_c[31:16]); end
    tick();
    checks++;
    if (mem_wdata !== pc_c[15:0]) begin failures++; $display("FAIL branch_push_lo got=%h want=%h", mem_wdata, pc_c[15:0]); end
    tick(4);
    rti = 1'b1; tick(); rti = 1'b0; tick(2);
    checks++;
    if (pc_value !== pc_c) begin failures++; $display("FAIL branch_return_pc got=%h want=%h", pc_value, pc_c); end
    tick();
  endtask

  task automatic test_queued();
    intr = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      intr = (c == 6 || c == 9) ? 1'b1 : 1'b0;
    end
    rti = 1'b1; tick(); rti = 1'b0; tick(3);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL queued_idle got=%b want=0", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL queued_reentry got=%b want=1", stall); end
    tick(8);
    do_return();
    for (int c = 0; c < 12; c++) begin
      tick();
      checks++;
      if ({stall, int_active} !== 2'b00) begin failures++; $display("FAIL queued_third_dropped c=%0d got=%b want=00", c, {stall, int_active}); end
    end
  endtask

  task automatic test_back_to_back();
    intr = 1'b1; tick(); intr = 1'b0; tick(8);
    intr = 1'b1; rti = 1'b1;
    tick(); intr = 1'b0; rti = 1'b0; tick(3);
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL b2b_rti_edge_idle got=%b want=0", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_rti_edge_entry got=%b want=1", stall); end
    tick(8);
    rti = 1'b1; tick(); rti = 1'b0; tick(2);
    intr = 1'b1;
    tick(); intr = 1'b0;
    checks++;
    if (stall !== 1'b0) begin failures++; $display("FAIL b2b_return_edge_idle got=%b want=0", stall); end
    tick();
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL b2b_return_edge_entry got=%b want=1", stall); end
    tick(8);
    do_return();
    tick();
  endtask

  task automatic test_reset_mid();
    rpc = 32'h0001_0020; gnt = 1; intr = 1'b1;
    tick(5);
    checks++;
    if (mem_wdata !== 16'h0020) begin failures++; $display("FAIL rstmid_push_lo got=%h want=0020", mem_wdata); end
    rst_n = 1'b0; #1;
    checks++;
    if (dut_vec !== 77'h0) begin failures++; $display("FAIL rstmid_outputs got=%h want=0", dut_vec); end
    tick(); rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if ({stall, mem_req} !== 2'b00) begin failures++; $display("FAIL rstmid_no_entry c=%0d got=%b want=00", c, {stall, mem_req}); end
    end
    intr = 1'b0; tick(); intr = 1'b1; tick(); intr = 1'b0;
    checks++;
    if (stall !== 1'b1) begin failures++; $display("FAIL rstmid_new_edge got=%b want=1", stall); end
    tick(8);
    do_return();
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      intr = ($urandom_range(0, 9) == 0);
      bp   = ($urandom_range(0, 3) == 0);
      rti  = ($urandom_range(0, 5) == 0);
      gnt  = ($urandom_range(0, 2) != 0);
      rpc  = $urandom;
      ccr  = 4'($urandom);
      if ($urandom_range(0, 30) == 0) begin vec_hi_w = 16'($urandom); vec_lo_w = 16'($urandom); end
      tick();
    end
    intr = 0; bp = 0; rti = 1; gnt = 1;
    tick(60);
    rti = 0;
    tick();
    checks++;
    if ({stall, int_active, mem_req} !== 3'b000) begin failures++; $display("FAIL random_drain_idle got=%b want=000", {stall, int_active, mem_req}); end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_return();
    test_grant_starvation();
    test_branch_collision();
    test_queued();
    test_back_to_back();
    test_reset_mid();
    test_random();
    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
